// File: rtl/hex_blink_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hex_blink_decoder
//  Description : Locks onto a blank/symbol alternating active-low 7-segment
//                stream, decodes each symbol to its hex code and flags
//                protocol violations.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_blink_decoder #(
    parameter int          LOCK_PAIRS = 2,
    parameter logic [6:0]  BLANK      = 7'b1111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    output logic [4:0]  code_out,
    output logic        locked,
    output logic        new_sym,
    output logic        err
);

    localparam logic [3:0] C_LOCK_PAIRS = LOCK_PAIRS[3:0];

    typedef enum logic [1:0] {
        ST_HUNT       = 2'd0,
        ST_WAIT_SYM   = 2'd1,
        ST_WAIT_BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  seg_q;
    logic        seg_vld_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  code_q, code_d;
    logic        locked_q, locked_d;
    logic        new_sym_q, new_sym_d;
    logic        err_q, err_d;

    logic        w_is_blank;
    logic        w_dec_valid;
    logic [3:0]  w_dec_code;
    logic        w_is_sym;
    logic        w_accept;
    logic        w_violation;

    // Input frame register: the FSM works on the frame captured one edge earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q     <= BLANK;
            seg_vld_q <= 1'b0;
        end else begin
            seg_q     <= seg_in;
            seg_vld_q <= 1'b1;
        end
    end

    always_comb begin
        w_dec_valid = 1'b1;
        w_dec_code  = 4'h0;
        case (seg_q)
            7'b1000000: w_dec_code = 4'h0;
            7'b1111001: w_dec_code = 4'h1;
            7'b0100100: w_dec_code = 4'h2;
            7'b0110000: w_dec_code = 4'h3;
            7'b0011001: w_dec_code = 4'h4;
            7'b0010010: w_dec_code = 4'h5;
            7'b0000010: w_dec_code = 4'h6;
            7'b1111000: w_dec_code = 4'h7;
            7'b0000000: w_dec_code = 4'h8;
            7'b0010000: w_dec_code = 4'h9;
            7'b0001000: w_dec_code = 4'hA;
            7'b0000011: w_dec_code = 4'hB;
            7'b1000110: w_dec_code = 4'hC;
            7'b0100001: w_dec_code = 4'hD;
            7'b0000110: w_dec_code = 4'hE;
            7'b0001110: w_dec_code = 4'hF;
            default:    w_dec_valid = 1'b0;
        endcase
    end

    assign w_is_blank = (seg_q == BLANK);
    assign w_is_sym   = w_dec_valid && !w_is_blank;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        new_sym_d   = 1'b0;
        err_d       = 1'b0;
        w_accept    = 1'b0;
        w_violation = 1'b0;

        if (seg_vld_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (w_is_blank) state_d = ST_WAIT_SYM;
                end
                ST_WAIT_SYM: begin
                    if (w_is_sym) begin
                        w_accept = 1'b1;
                        code_d   = {1'b0, w_dec_code};
                        cnt_d    = (cnt_q == C_LOCK_PAIRS) ? cnt_q : cnt_q + 4'd1;
                        state_d  = ST_WAIT_BLANK;
                    end else begin
                        w_violation = 1'b1;
                    end
                end
                ST_WAIT_BLANK: begin
                    if (w_is_blank) state_d = ST_WAIT_SYM;
                    else            w_violation = 1'b1;
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // A blank offender still marks a frame boundary, so resync from it.
        if (w_violation) begin
            cnt_d   = 4'd0;
            err_d   = locked_q;
            state_d = w_is_blank ? ST_WAIT_SYM : ST_HUNT;
        end

        locked_d = (cnt_d == C_LOCK_PAIRS);

        if (w_accept) begin
            new_sym_d = (locked_d && !locked_q) ||
                        (locked_q && (code_d != code_q));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            cnt_q     <= 4'd0;
            code_q    <= 5'd0;
            locked_q  <= 1'b0;
            new_sym_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            locked_q  <= locked_d;
            new_sym_q <= new_sym_d;
            err_q     <= err_d;
        end
    end

    assign code_out = code_q;
    assign locked   = locked_q;
    assign new_sym  = new_sym_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_blink_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_blink_decoder
//  Description : Directed vector bench for hex_blink_decoder (LOCK_PAIRS 2 and 1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_blink_decoder;

    localparam logic [6:0] C_BLK = 7'b1111111;
    localparam logic [6:0] C_S0  = 7'b1000000;
    localparam logic [6:0] C_S1  = 7'b1111001;
    localparam logic [6:0] C_S7  = 7'b1111000;
    localparam logic [6:0] C_SA  = 7'b0001000;
    localparam logic [6:0] C_SB  = 7'b0000011;
    localparam logic [6:0] C_INV = 7'b0110110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = C_BLK;
    logic [4:0] code_a, code_b;
    logic       locked_a, locked_b, new_a, new_b, err_a, err_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_blink_decoder #(.LOCK_PAIRS(2), .BLANK(7'b1111111)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in),
        .code_out(code_a), .locked(locked_a), .new_sym(new_a), .err(err_a)
    );

    hex_blink_decoder #(.LOCK_PAIRS(1), .BLANK(7'b1111111)) dut1 (
        .clk(clk), .reset(reset), .seg_in(seg_in),
        .code_out(code_b), .locked(locked_b), .new_sym(new_b), .err(err_b)
    );

    // Outputs expected just after the edge that samples 'seg'
    // (i.e. the effect of the previous frame).
    typedef struct packed {
        logic [6:0] seg;
        logic [4:0] code;
        logic       lk;
        logic       ns;
        logic       er;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic [6:0] s);
        seg_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input int idx, input logic [4:0] c,
                         input logic l, input logic n, input logic e);
        chk({nm, "_code"},   idx, code_a, c);
        chk({nm, "_locked"}, idx, {4'd0, locked_a}, {4'd0, l});
        chk({nm, "_new"},    idx, {4'd0, new_a}, {4'd0, n});
        chk({nm, "_err"},    idx, {4'd0, err_a}, {4'd0, e});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(C_BLK);
        step(C_BLK);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{C_BLK, 5'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{C_S0,  5'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{C_BLK, 5'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{C_S0,  5'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{C_BLK, 5'h00, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{C_SA,  5'h00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{C_BLK, 5'h0A, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{C_SA,  5'h0A, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{C_S1,  5'h0A, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{C_S1,  5'h0A, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{C_BLK, 5'h0A, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{C_S1,  5'h0A, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{C_BLK, 5'h01, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{C_S1,  5'h01, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{C_BLK, 5'h01, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{C_INV, 5'h01, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{C_BLK, 5'h01, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{C_S7,  5'h01, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{C_BLK, 5'h07, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{C_S7,  5'h07, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{C_BLK, 5'h07, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{C_BLK, 5'h07, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{C_SB,  5'h07, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{C_BLK, 5'h0B, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk_a("reset", 0, 5'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].seg);
            chk_a("vec", i, vecs[i].code, vecs[i].lk, vecs[i].ns, vecs[i].er);
            chk("excl", i, {4'd0, new_a & err_a}, 5'd0);
        end

        // Unlocked junk blanks: no err, one pair counted; LOCK_PAIRS=1 locks.
        do_reset();
        step(C_BLK);
        step(C_BLK);
        chk("unl_err_a", 1, {4'd0, err_a}, 5'd0);
        step(C_BLK);
        chk("unl_err_a", 2, {4'd0, err_a}, 5'd0);
        chk("unl_err_b", 2, {4'd0, err_b}, 5'd0);
        step(C_S1);
        chk("unl_err_a", 3, {4'd0, err_a}, 5'd0);
        chk("unl_err_b", 3, {4'd0, err_b}, 5'd0);
        step(C_BLK);
        chk_a("unl_a", 4, 5'h01, 1'b0, 1'b0, 1'b0);
        chk("unl_b_code",   4, code_b, 5'h01);
        chk("unl_b_locked", 4, {4'd0, locked_b}, 5'd1);
        chk("unl_b_new",    4, {4'd0, new_b}, 5'd1);
        chk("unl_b_err",    4, {4'd0, err_b}, 5'd0);
        step(C_S1);
        chk("unl_b_new_clr", 5, {4'd0, new_b}, 5'd0);
        step(C_BLK);
        chk_a("unl_lock2", 6, 5'h01, 1'b1, 1'b1, 1'b0);
        chk("rep_b_new", 6, {4'd0, new_b}, 5'd0);

        // Reset mid-lock, then relock on b.
        reset = 1'b1;
        step(C_S1);
        reset = 1'b0;
        chk_a("midrst", 0, 5'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst_b_locked", 0, {4'd0, locked_b}, 5'd0);
        step(C_BLK);
        step(C_SB);
        step(C_BLK);
        chk_a("relock", 3, 5'h0B, 1'b0, 1'b0, 1'b0);
        step(C_SB);
        step(C_BLK);
        chk_a("relock", 5, 5'h0B, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
